cdb_arb: RTL and testbench

CDB_ARB -- requirements
Module: cdb_arb

---
 rtl/cdb_arb.sv | 175 +++++++++++++++++
 tb/tb_cdb_arb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arb.sv
// Purpose: merges results from NUM_REQ functional units onto NUM_CDB broadcast lanes,
//          with a small per-requestor FIFO and a round-robin grant across heads.
// Latency: 2 cycles minimum (push at edge c, grant and registered broadcast at edge c+1).
// Backpressure: req_ready[i] is low while FIFO i is full (based on registered count only);
//               a requestor that sees req_ready low must hold its result.
// Ports:
//   clock, reset (sync, active-high), squash (flush all buffered results)
//   req_valid/req_prn/req_robn/req_value -> per-requestor result offer, req_ready <- accept
//   cdb_valid/cdb_prn/cdb_robn/cdb_value -> registered broadcast lanes, packed from lane 0
//   stall_cnt -> saturating count of cycles with more non-empty heads than lanes
module cdb_arb #(
    parameter int NUM_REQ   = 8,
    parameter int NUM_CDB   = 3,
    parameter int BUF_DEPTH = 2,
    parameter int DATA_W    = 32,
    parameter int PRN_W     = 6,
    parameter int ROBN_W    = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      squash,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*PRN_W-1:0]  req_prn,
    input  logic [NUM_REQ*ROBN_W-1:0] req_robn,
    input  logic [NUM_REQ*DATA_W-1:0] req_value,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_CDB-1:0]        cdb_valid,
    output logic [NUM_CDB*PRN_W-1:0]  cdb_prn,
    output logic [NUM_CDB*ROBN_W-1:0] cdb_robn,
    output logic [NUM_CDB*DATA_W-1:0] cdb_value,
    output logic [31:0]               stall_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [PRN_W-1:0]  prn;
        logic [ROBN_W-1:0] robn;
        logic [DATA_W-1:0] value;
    } entry_t;

    entry_t           mem    [NUM_REQ][BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr [NUM_REQ];
    logic [PTR_W-1:0] wr_ptr [NUM_REQ];
    logic [CNT_W-1:0] count  [NUM_REQ];
    logic [IDX_W-1:0] rr_ptr;

    logic [NUM_REQ-1:0] nonempty;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_CDB-1:0] lane_vld;
    entry_t             lane_dat [NUM_CDB];
    logic [IDX_W-1:0]   last_idx;
    logic               any_grant;
    logic               over_sub;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == BUF_DEPTH - 1) return '0;
        return p + PTR_W'(1);
    endfunction

    // Ready depends only on the registered count, so a same-cycle pop never
    // opens the FIFO early.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (int'(count[i]) < BUF_DEPTH);
            nonempty[i]  = (count[i] != '0);
            push[i]      = req_valid[i] & req_ready[i] & ~squash;
        end
    end

    // Round-robin selection without dynamic indexing: each requestor's position
    // in the scan (distance from rr_ptr) gives its rank among non-empty heads;
    // rank k lands on lane k, and ranks beyond the lane count are not granted.
    always_comb begin
        int pos  [NUM_REQ];
        int rank [NUM_REQ];
        int nz;
        int best_pos;
        nz        = 0;
        best_pos  = -1;
        grant     = '0;
        lane_vld  = '0;
        last_idx  = rr_ptr;
        any_grant = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) lane_dat[k] = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos[i] = i - int'(rr_ptr);
            if (pos[i] < 0) pos[i] = pos[i] + NUM_REQ;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            rank[i] = 0;
            for (int i2 = 0; i2 < NUM_REQ; i2++) begin
                if (nonempty[i2] && (pos[i2] < pos[i])) rank[i] = rank[i] + 1;
            end
            if (nonempty[i]) nz = nz + 1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = nonempty[i] && (rank[i] < NUM_CDB);
            if (grant[i]) begin
                any_grant = 1'b1;
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (rank[i] == k) begin
                        lane_vld[k] = 1'b1;
                        lane_dat[k] = mem[i][rd_ptr[i]];
                    end
                end
                // Furthest-from-rr_ptr grant is the last one in scan order.
                if (pos[i] > best_pos) begin
                    best_pos = pos[i];
                    last_idx = IDX_W'(i);
                end
            end
        end
        over_sub = (nz > NUM_CDB);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr    <= '0;
            stall_cnt <= '0;
            cdb_valid <= '0;
            cdb_prn   <= '0;
            cdb_robn  <= '0;
            cdb_value <= '0;
        end else if (squash) begin
            // Flush buffered and in-flight results; arbitration history is kept.
            for (int i = 0; i < NUM_REQ; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            cdb_valid <= '0;
            cdb_prn   <= '0;
            cdb_robn  <= '0;
            cdb_value <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push[i])  wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                if (grant[i]) rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                if (push[i] && !grant[i])      count[i] <= count[i] + CNT_W'(1);
                else if (!push[i] && grant[i]) count[i] <= count[i] - CNT_W'(1);
            end
            for (int k = 0; k < NUM_CDB; k++) begin
                cdb_valid[k]                     <= lane_vld[k];
                cdb_prn[k*PRN_W +: PRN_W]        <= lane_dat[k].prn;
                cdb_robn[k*ROBN_W +: ROBN_W]     <= lane_dat[k].robn;
                cdb_value[k*DATA_W +: DATA_W]    <= lane_dat[k].value;
            end
            if (any_grant) begin
                rr_ptr <= (int'(last_idx) == NUM_REQ - 1) ? '0 : last_idx + IDX_W'(1);
            end
            if (over_sub && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count/pointers.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= '{prn:   req_prn[i*PRN_W +: PRN_W],
                                       robn:  req_robn[i*ROBN_W +: ROBN_W],
                                       value: req_value[i*DATA_W +: DATA_W]};
            end
        end
    end

endmodule

// File: tb/tb_cdb_arb.sv
// Bench for cdb_arb: a queue-based model of the arbiter checked every cycle,
// plus directed scenarios with hand-computed lane contents.
module tb_cdb_arb;

    localparam int NR = 8;
    localparam int NC = 3;
    localparam int BD = 2;
    localparam int DW = 32;
    localparam int PW = 6;
    localparam int RW = 5;

    logic              clock;
    logic              reset;
    logic              squash;
    logic [NR-1:0]     req_valid;
    logic [NR*PW-1:0]  req_prn;
    logic [NR*RW-1:0]  req_robn;
    logic [NR*DW-1:0]  req_value;
    logic [NR-1:0]     req_ready;
    logic [NC-1:0]     cdb_valid;
    logic [NC*PW-1:0]  cdb_prn;
    logic [NC*RW-1:0]  cdb_robn;
    logic [NC*DW-1:0]  cdb_value;
    logic [31:0]       stall_cnt;

    cdb_arb #(
        .NUM_REQ(NR), .NUM_CDB(NC), .BUF_DEPTH(BD),
        .DATA_W(DW), .PRN_W(PW), .ROBN_W(RW)
    ) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .req_valid(req_valid), .req_prn(req_prn), .req_robn(req_robn),
        .req_value(req_value), .req_ready(req_ready),
        .cdb_valid(cdb_valid), .cdb_prn(cdb_prn), .cdb_robn(cdb_robn),
        .cdb_value(cdb_value), .stall_cnt(stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [PW-1:0] prn;
        logic [RW-1:0] robn;
        logic [DW-1:0] value;
    } ent_t;

    ent_t           mq [NR][$];
    int             m_rr;
    logic [31:0]    m_stall;
    logic [NC-1:0]  e_valid;
    logic [NC*PW-1:0] e_prn;
    logic [NC*RW-1:0] e_robn;
    logic [NC*DW-1:0] e_value;
    bit             chk_en = 0;

    int             m_n, m_nz, m_last, m_idx;
    logic [NR-1:0]  m_g, m_acc;
    ent_t           m_e;

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) mq[i].delete();
            m_rr = 0; m_stall = 0;
            e_valid = '0; e_prn = '0; e_robn = '0; e_value = '0;
            chk_en = 1;
        end else if (squash) begin
            for (int i = 0; i < NR; i++) mq[i].delete();
            e_valid = '0; e_prn = '0; e_robn = '0; e_value = '0;
        end else begin
            m_n = 0; m_nz = 0; m_last = -1; m_g = '0;
            e_valid = '0; e_prn = '0; e_robn = '0; e_value = '0;
            for (int j = 0; j < NR; j++) begin
                m_idx = (m_rr + j) % NR;
                if (mq[m_idx].size() > 0) begin
                    m_nz++;
                    if (m_n < NC) begin
                        m_e = mq[m_idx][0];
                        m_g[m_idx] = 1'b1;
                        e_valid[m_n] = 1'b1;
                        e_prn[m_n*PW +: PW]   = m_e.prn;
                        e_robn[m_n*RW +: RW]  = m_e.robn;
                        e_value[m_n*DW +: DW] = m_e.value;
                        m_last = m_idx;
                        m_n++;
                    end
                end
            end
            if (m_nz > NC && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (m_last >= 0) m_rr = (m_last + 1) % NR;
            for (int i = 0; i < NR; i++) m_acc[i] = req_valid[i] && (mq[i].size() < BD);
            for (int i = 0; i < NR; i++) begin
                if (m_g[i]) void'(mq[i].pop_front());
                if (m_acc[i]) begin
                    m_e.prn   = req_prn[i*PW +: PW];
                    m_e.robn  = req_robn[i*RW +: RW];
                    m_e.value = req_value[i*DW +: DW];
                    mq[i].push_back(m_e);
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    logic [NR-1:0] e_ready;
    always @(negedge clock) begin
        if (chk_en) begin
            for (int i = 0; i < NR; i++) e_ready[i] = (mq[i].size() < BD);
            chk("cdb_valid", 128'(cdb_valid), 128'(e_valid));
            chk("cdb_prn",   128'(cdb_prn),   128'(e_prn));
            chk("cdb_robn",  128'(cdb_robn),  128'(e_robn));
            chk("cdb_value", 128'(cdb_value), 128'(e_value));
            chk("req_ready", 128'(req_ready), 128'(e_ready));
            chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
        end
    end

    // Collects requestor 0's broadcasts (tagged prn=1) during the backpressure test.
    bit bp_mon = 0;
    int bp_q [$];
    always @(negedge clock) begin
        if (bp_mon) begin
            for (int k = 0; k < NC; k++) begin
                if (cdb_valid[k] && cdb_prn[k*PW +: PW] == PW'(1)) bp_q.push_back(int'(cdb_value[k*DW +: DW]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int i, input int prn, input int robn, input int val);
        req_valid[i]            = 1'b1;
        req_prn[i*PW +: PW]     = PW'(prn);
        req_robn[i*RW +: RW]    = RW'(robn);
        req_value[i*DW +: DW]   = DW'(val);
    endtask

    task automatic clr();
        req_valid = '0; req_prn = '0; req_robn = '0; req_value = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    function automatic logic [127:0] pk(input int w, input int a, input int b, input int c);
        return 128'(a) | (128'(b) << w) | (128'(c) << (2 * w));
    endfunction

    int  k0;
    bit  acc0;

    initial begin
        reset = 1'b1; squash = 1'b0; clr();
        step();
        do_reset();

        // Reset state
        @(negedge clock);
        chk("rst_ready", 128'(req_ready), 128'(8'hFF));
        chk("rst_valid", 128'(cdb_valid), 128'(0));
        chk("rst_stall", 128'(stall_cnt), 128'(0));

        // Single result: req 2 accepted now, broadcast two cycles later on lane 0
        drive(2, 5, 3, 25);
        step(); clr();
        step();
        @(negedge clock);
        chk("single_valid", 128'(cdb_valid), 128'(3'b001));
        chk("single_prn",   128'(cdb_prn),   128'(5));
        chk("single_robn",  128'(cdb_robn),  128'(3));
        chk("single_value", 128'(cdb_value), 128'(25));
        step();

        // Overload: four heads, three lanes
        do_reset();
        for (int i = 0; i < 4; i++) drive(i, 10 + i, i, 2);
        step(); clr();
        step();
        @(negedge clock);
        chk("ovl_valid0", 128'(cdb_valid), 128'(3'b111));
        chk("ovl_prn0",   128'(cdb_prn),   pk(PW, 10, 11, 12));
        chk("ovl_stall0", 128'(stall_cnt), 128'(1));
        step();
        @(negedge clock);
        chk("ovl_valid1", 128'(cdb_valid), 128'(3'b001));
        chk("ovl_prn1",   128'(cdb_prn),   128'(13));
        chk("ovl_stall1", 128'(stall_cnt), 128'(1));
        step();

        // Backpressure on requestor 0 while 1..7 keep every lane busy
        do_reset();
        bp_mon = 1;
        for (int i = 1; i < NR; i++) drive(i, 8 + i, i, 200 + i);
        step();
        k0 = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (k0 < 3) drive(0, 1, 0, 100 + k0);
            else req_valid[0] = 1'b0;
            @(negedge clock);
            if (cyc == 2) chk("bp_ready_full", 128'(req_ready[0]), 128'(0));
            if (cyc == 3) chk("bp_ready_pop",  128'(req_ready[0]), 128'(1));
            acc0 = req_valid[0] && req_ready[0];
            step();
            if (acc0) k0++;
        end
        clr();
        for (int c = 0; c < 10; c++) step();
        bp_mon = 0;
        chk("bp_count", 128'(bp_q.size()), 128'(3));
        for (int j = 0; j < bp_q.size() && j < 3; j++) chk("bp_order", 128'(bp_q[j]), 128'(100 + j));

        // Fairness: all requestors continuously valid; requestor 0 uses prn 0
        do_reset();
        for (int i = 0; i < NR; i++) drive(i, i, i, 300 + i);
        step();
        step();
        @(negedge clock);
        chk("fair_valid", 128'(cdb_valid), 128'(3'b111));
        chk("fair_prn0",  128'(cdb_prn),   pk(PW, 0, 1, 2));
        chk("fair_g0",    128'(cdb_robn),  pk(RW, 0, 1, 2));
        step();
        @(negedge clock);
        chk("fair_g1",    128'(cdb_robn),  pk(RW, 3, 4, 5));
        step();
        @(negedge clock);
        chk("fair_g2",    128'(cdb_robn),  pk(RW, 6, 7, 0));
        for (int c = 0; c < 6; c++) step();
        clr();
        for (int c = 0; c < 8; c++) step();

        // Squash with four results buffered; a push offered during squash is dropped
        do_reset();
        for (int i = 0; i < 4; i++) drive(i, 30 + i, i, 400 + i);
        step(); clr();
        squash = 1'b1;
        drive(5, 35, 5, 405);
        step();
        squash = 1'b0; clr();
        @(negedge clock);
        chk("sq_valid", 128'(cdb_valid), 128'(0));
        chk("sq_ready", 128'(req_ready), 128'(8'hFF));
        chk("sq_stall", 128'(stall_cnt), 128'(0));
        for (int c = 0; c < 4; c++) begin
            step();
            @(negedge clock);
            chk("sq_stale", 128'(cdb_valid), 128'(0));
        end
        step();

        // Reset mid-operation with five results buffered
        for (int i = 0; i < 5; i++) drive(i, 20 + i, i, 500 + i);
        step();
        req_valid[3] = 1'b0; req_valid[4] = 1'b0;
        step();
        @(negedge clock);
        chk("mid_valid_pre", 128'(cdb_valid), 128'(3'b111));
        chk("mid_robn_pre",  128'(cdb_robn),  pk(RW, 0, 1, 2));
        chk("mid_stall_pre", 128'(stall_cnt), 128'(1));
        reset = 1'b1; clr();
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("mid_valid", 128'(cdb_valid), 128'(0));
        chk("mid_prn",   128'(cdb_prn),   128'(0));
        chk("mid_robn",  128'(cdb_robn),  128'(0));
        chk("mid_value", 128'(cdb_value), 128'(0));
        chk("mid_stall", 128'(stall_cnt), 128'(0));
        chk("mid_ready", 128'(req_ready), 128'(8'hFF));
        // rr pointer back at 0: grant order restarts at requestor 0
        for (int i = 0; i < 4; i++) drive(i, 40 + i, i, 600 + i);
        step(); clr();
        step();
        @(negedge clock);
        chk("mid_rr_order", 128'(cdb_robn), pk(RW, 0, 1, 2));
        for (int c = 0; c < 4; c++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
